adc_trigger_capture: RTL and testbench
======================================

# adc_trigger_capture

Triggered snapshot buffer sitting directly downstream of the LVDS deserializer, in the `AdcFrmClk` domain. It consumes the aligned per-channel sample words and their valid flags, and keeps a circular history of all channels. On a level-crossing or forced trigger it freezes a window of `Depth` samples (`PreTrig` before the trigger, the rest from the trigger onward). It then streams the window out over a ready/valid port for host readout.

## Interface
Parameters:
- `AdcChnls`, 8, number of channels in the packed input bus (1..8).
- `Depth`, 1024, capture window length in samples; must be a power of two.
- `AddrBits`, 10, log2(`Depth`).

Ports:
- `AdcFrmClk`, in, 1, sample clock; the only clock.
- `SysRst_n`, in, 1, reset; asynchronous assert, active-low.
- `AdcDataValid`, in, 8, per-channel alignment-done flags. A sample is accepted only when bits [`AdcChnls`-1:0] are all 1.
- `AdcData`, in, 16*`AdcChnls`, packed channel words; Ch0 is in [15:0].
- `Arm`, in, 1, single-cycle request to start a capture.
- `TrigChnl`, in, 3, channel compared against the level; sampled at `Arm`.
- `TrigLevel`, in, 16, unsigned threshold; sampled at `Arm`.
- `TrigForce`, in, 1, immediate trigger (pulse).
- `PreTrig`, in, `AddrBits`, number of pre-trigger samples; sampled at `Arm`.
- `Busy`, out, 1, high in any state other than IDLE.
- `Triggered`, out, 1, high from the trigger until the end of readout.
- `Done`, out, 1, high after a completed readout; cleared by the next accepted `Arm`.
- `RdData`, out, 16*`AdcChnls`, readout word.
- `RdValid`, out, 1, readout word is valid.
- `RdReady`, in, 1, consumer accepts the word.
- `RdLast`, out, 1, marks the final word of the window.

## Operation
- Storage: one `Depth` x 16*`AdcChnls` simple dual-port RAM with synchronous read. Write pointer `wa` is `AddrBits` wide and wraps modulo `Depth`.
- Accepted sample ("acc"): all valid bits high in a capturing state. Only an acc writes `AdcData` to `wa` and increments `wa`. Non-acc cycles write nothing, count nothing and leave the edge-detect history unchanged.
- State IDLE:
  - `Arm` latches `TrigChnl`, `TrigLevel` and `pre = min(PreTrig, Depth-1)`.
  - It clears `Done`, `wa` and the count, and clears `PrevOk`.
  - Next state is PRE, or WAIT if `pre` = 0.
  - `Arm` in any other state is ignored.
- State PRE: writes accs; moves to WAIT once `pre` accs have been written. Triggers are ignored in PRE.
- State WAIT: writes accs. A trigger fires on an acc cycle when either condition holds:
  - `TrigForce` = 1; or
  - `PrevOk` = 1 and prev < `TrigLevel` <= cur, where cur is the selected channel word of this acc and prev is that word from the previous acc.
- On trigger:
  - The trigger sample is written.
  - `ta = wa` (address of the trigger sample) is recorded.
  - The post count `post = Depth - pre` is loaded, already counting the trigger sample as 1.
  - Next state is POST.
- State POST: writes accs until `post` samples including the trigger sample are stored, then moves to READ.
- State READ:
  - Reads `Depth` words starting at `ra = ta - pre` (mod `Depth`), in increasing address order with wrap.
  - `RdLast` accompanies word `Depth`-1.
  - After the handshake of the last word: `Done` goes to 1, `Triggered` goes to 0, and the state returns to IDLE.
  - Incoming samples are not written during READ.
- `PrevOk` is set by the first acc after `Arm`. `prev` updates on every acc in PRE, WAIT and POST.
- Reset values: state IDLE; `Busy`, `Triggered`, `Done`, `RdValid`, `RdLast` = 0; `RdData` = 0; `wa` = 0. RAM contents are not cleared.
- Reset mid-capture or mid-readout aborts to IDLE immediately. The partial window is discarded.

## Timing
- `Arm` accepted at edge n: `Busy` = 1 from n+1; the first possible write is the acc at cycle n+1.
- Trigger acc at edge t: `Triggered` = 1 from t+1.
- The last POST write at edge p moves the state to READ at p+1. The first `RdValid` = 1 appears at p+2 (one cycle of RAM latency plus an output register).
- Readout handshake:
  - A word transfers on each edge where `RdValid` && `RdReady`.
  - While `RdValid` && !`RdReady`, `RdData` and `RdLast` hold stable.
  - With `RdReady` held at 1, throughput is one word per cycle, so `Depth` words take `Depth` consecutive cycles.
  - This requires a 2-entry skid or prefetch register; a bubble after a stall is not permitted.
- `Done` = 1 on the cycle after the last handshake. `RdValid` = 0 on that same cycle.
- `TrigForce` and a level crossing on the same acc count as a single trigger.

## Test plan
Bench configuration: `Depth` = 16, `AdcChnls` = 4. Stimulus is a ramp where each channel equals the sample index.
- Level trigger:
  - Stimulus: `PreTrig` = 4, `TrigChnl` = 2, `TrigLevel` = 20, continuous valid, `RdReady` = 1.
  - Required: readout words carry indices 16..31, `RdLast` on index 31, `Done` one cycle after.
- Force trigger with `PreTrig` = 0:
  - Stimulus: `TrigForce` pulsed on the 3rd acc after `Arm`.
  - Required: the first read word is index 2 and 16 words are read.
- Valid gaps and early force:
  - Stimulus: `AdcDataValid`[1] dropped on every 3rd cycle, `TrigForce` held during PRE.
  - Required: dropped cycles are absent from the window, the force in PRE is ignored, and the trigger is taken on the first WAIT acc.
- Backpressure:
  - Stimulus: `RdReady` toggled pseudo-randomly.
  - Required: 16 words in order, none lost or duplicated, `RdData` stable during stalls.
- Reset and clamp:
  - Stimulus: `SysRst_n` pulsed low during POST, then a re-arm with `PreTrig` = 15.
  - Required: all outputs at their reset values during reset. The new capture gives 15 pre-trigger words plus the trigger word as the last word.

Source files
------------

// File: rtl/adc_trigger_capture.sv
// Triggered snapshot buffer: circular multi-channel sample history, level/force trigger,
// and a ready/valid readout of the frozen Depth-sample window.
module adc_trigger_capture #(
   parameter int unsigned AdcChnls = 8,
   parameter int unsigned Depth    = 1024,
   parameter int unsigned AddrBits = 10
) (
   input  logic                    AdcFrmClk,
   input  logic                    SysRst_n,
   input  logic [7:0]              AdcDataValid,
   input  logic [16*AdcChnls-1:0]  AdcData,
   input  logic                    Arm,
   input  logic [2:0]              TrigChnl,
   input  logic [15:0]             TrigLevel,
   input  logic                    TrigForce,
   input  logic [AddrBits-1:0]     PreTrig,
   output logic                    Busy,
   output logic                    Triggered,
   output logic                    Done,
   output logic [16*AdcChnls-1:0]  RdData,
   output logic                    RdValid,
   input  logic                    RdReady,
   output logic                    RdLast
);
   localparam int unsigned W       = 16 * AdcChnls;
   localparam int unsigned CntBits = AddrBits + 1;

   typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StRead} state_e;
   state_e state_q, state_d;

   logic [2:0]          chnl_q;
   logic [15:0]         level_q, prev_q, cur;
   logic [AddrBits-1:0] pre_q, pre_in, wa_q, ra_q, pop_cnt_q;
   logic [CntBits-1:0]  cnt_q, iss_q, post_rem;
   logic                prev_ok_q, triggered_q, done_q;
   logic                acc, trig, pre_done, post_done, arm_ok, issue, pop, last_pop;
   logic [2:0]          occ;

   logic [W-1:0]        mem [Depth];
   logic [W-1:0]        ram_q;
   logic                pend_q;
   logic [W-1:0]        fifo_q [2];
   logic [1:0]          fcnt_q;
   logic                wr_ptr_q, rd_ptr_q;

   assign pre_in   = ({1'b0, PreTrig} > CntBits'(Depth - 1)) ? AddrBits'(Depth - 1) : PreTrig;
   assign arm_ok   = (state_q == StIdle) && Arm;
   assign acc      = (&AdcDataValid[AdcChnls-1:0]) &&
                     ((state_q == StPre) || (state_q == StWait) || (state_q == StPost));
   assign post_rem = CntBits'(Depth - 1) - {1'b0, pre_q};

   always_comb begin
      cur = '0;
      for (int unsigned i = 0; i < AdcChnls; i++) begin
         if (chnl_q == 3'(i)) cur = AdcData[16*i +: 16];
      end
   end

   assign trig      = acc && (state_q == StWait) &&
                      (TrigForce || (prev_ok_q && (prev_q < level_q) && (level_q <= cur)));
   assign pre_done  = acc && (state_q == StPre) && ((cnt_q + CntBits'(1)) == {1'b0, pre_q});
   assign post_done = acc && (state_q == StPost) && (cnt_q == CntBits'(1));

   // Credit check: words in the FIFO plus the one in flight from the RAM never exceed two.
   assign pop      = RdValid && RdReady;
   assign last_pop = pop && RdLast;
   assign occ      = {1'b0, fcnt_q} + {2'b00, pend_q} - {2'b00, pop};
   assign issue    = (state_q == StRead) && (iss_q != CntBits'(Depth)) && (occ < 3'd2);

   always_ff @(posedge AdcFrmClk or negedge SysRst_n) begin
      if (!SysRst_n) state_q <= StIdle;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (Arm)       state_d = (pre_in == '0) ? StWait : StPre;
         StPre:   if (pre_done)  state_d = StWait;
         StWait:  if (trig)      state_d = (post_rem == '0) ? StRead : StPost;
         StPost:  if (post_done) state_d = StRead;
         StRead:  if (last_pop)  state_d = StIdle;
         default:                state_d = StIdle;
      endcase
   end

   always_comb begin
      Busy      = (state_q != StIdle);
      Triggered = triggered_q;
      Done      = done_q;
      RdValid   = (fcnt_q != 2'd0);
      RdData    = fifo_q[rd_ptr_q];
      RdLast    = (fcnt_q != 2'd0) && (pop_cnt_q == AddrBits'(Depth - 1));
   end

   always_ff @(posedge AdcFrmClk or negedge SysRst_n) begin
      if (!SysRst_n) begin
         chnl_q      <= '0;
         level_q     <= '0;
         pre_q       <= '0;
         wa_q        <= '0;
         ra_q        <= '0;
         cnt_q       <= '0;
         iss_q       <= '0;
         pop_cnt_q   <= '0;
         prev_q      <= '0;
         prev_ok_q   <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         if (arm_ok) begin
            chnl_q    <= TrigChnl;
            level_q   <= TrigLevel;
            pre_q     <= pre_in;
            done_q    <= 1'b0;
            wa_q      <= '0;
            cnt_q     <= '0;
            iss_q     <= '0;
            pop_cnt_q <= '0;
            prev_ok_q <= 1'b0;
         end
         if (acc) begin
            wa_q      <= wa_q + AddrBits'(1);
            prev_q    <= cur;
            prev_ok_q <= 1'b1;
         end
         if (acc && (state_q == StPre))  cnt_q <= cnt_q + CntBits'(1);
         if (acc && (state_q == StPost)) cnt_q <= cnt_q - CntBits'(1);
         if (trig) begin
            triggered_q <= 1'b1;
            ra_q        <= wa_q - pre_q;
            cnt_q       <= post_rem;
         end
         if (issue) begin
            ra_q  <= ra_q + AddrBits'(1);
            iss_q <= iss_q + CntBits'(1);
         end
         if (pop) pop_cnt_q <= pop_cnt_q + AddrBits'(1);
         if (last_pop) begin
            done_q      <= 1'b1;
            triggered_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge AdcFrmClk) begin
      if (acc)   mem[wa_q] <= AdcData;
      if (issue) ram_q     <= mem[ra_q];
   end

   always_ff @(posedge AdcFrmClk or negedge SysRst_n) begin
      if (!SysRst_n) begin
         pend_q    <= 1'b0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         fcnt_q    <= 2'd0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
      end else begin
         pend_q <= issue;
         if (pend_q) begin
            fifo_q[wr_ptr_q] <= ram_q;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         fcnt_q <= fcnt_q + {1'b0, pend_q} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed bench for adc_trigger_capture (Depth 16, 4 channels) with a window model built from
// the logged accepted samples and a per-cycle readout checker.
module tb_adc_trigger_capture;
   localparam int unsigned NCh   = 4;
   localparam int unsigned Dep   = 16;
   localparam int unsigned ABits = 4;

   logic              clk, rst_n;
   logic [7:0]        AdcDataValid;
   logic [16*NCh-1:0] AdcData;
   logic              Arm, TrigForce, RdReady;
   logic [2:0]        TrigChnl;
   logic [15:0]       TrigLevel;
   logic [ABits-1:0]  PreTrig;
   logic              Busy, Triggered, Done, RdValid, RdLast;
   logic [16*NCh-1:0] RdData;

   adc_trigger_capture #(.AdcChnls(NCh), .Depth(Dep), .AddrBits(ABits)) dut (
      .AdcFrmClk(clk), .SysRst_n(rst_n), .AdcDataValid(AdcDataValid), .AdcData(AdcData),
      .Arm(Arm), .TrigChnl(TrigChnl), .TrigLevel(TrigLevel), .TrigForce(TrigForce),
      .PreTrig(PreTrig), .Busy(Busy), .Triggered(Triggered), .Done(Done), .RdData(RdData),
      .RdValid(RdValid), .RdReady(RdReady), .RdLast(RdLast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int fails  = 0;

   // Model state: every accepted sample since the last Arm, with its force flag.
   int        log_val[$];
   bit        log_frc[$];
   bit        log_en = 1'b0;
   int        pre_m  = 0;
   int        lvl_m  = 0;
   logic [15:0] smp  = 16'd0;

   int done_cnt = 0;
   int got[16];

   task automatic chk(input bit ok, input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] wexp(input int v);
      logic [15:0] s;
      s = 16'(v);
      return {s, s, s, s};
   endfunction

   // Trigger is the first accepted sample at or after index pre that is forced or crosses upward.
   function automatic int find_k();
      for (int i = pre_m; i < log_val.size(); i++) begin
         if (log_frc[i] || (i >= 1 && log_val[i-1] < lvl_m && lvl_m <= log_val[i])) return i;
      end
      return -1;
   endfunction

   initial begin : monitor
      int   rd_n, mk, idx;
      bit   stall_p, last_p, hold_l;
      logic [63:0] hold_d;
      rd_n = 0; mk = -1; stall_p = 0; last_p = 0; hold_l = 0; hold_d = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rd_n = 0; stall_p = 0; last_p = 0;
         end else begin
            if (Arm && !Busy) begin
               rd_n = 0; stall_p = 0; last_p = 0;
            end
            if (last_p) begin
               chk(Done == 1'b1, "done_after_last", 64'(Done), 64'd1);
               chk(RdValid == 1'b0, "valid_after_last", 64'(RdValid), 64'd0);
               chk(Triggered == 1'b0, "trig_after_last", 64'(Triggered), 64'd0);
               chk(Busy == 1'b0, "busy_after_last", 64'(Busy), 64'd0);
               last_p = 0;
               done_cnt++;
            end
            if (stall_p) begin
               chk(RdValid && RdData == hold_d && RdLast == hold_l, "stall_hold", RdData, hold_d);
            end
            if (RdValid && RdReady) begin
               if (rd_n >= 16) begin
                  chk(1'b0, "extra_word", 64'(rd_n), 64'd16);
               end else begin
                  if (rd_n == 0) mk = find_k();
                  idx = mk - pre_m + rd_n;
                  if (mk < 0 || idx < 0 || idx >= log_val.size())
                     chk(1'b0, "window_index", 64'(idx), 64'(log_val.size()));
                  else
                     chk(RdData == wexp(log_val[idx]), "rd_data", RdData, wexp(log_val[idx]));
                  chk(RdLast == (rd_n == 15), "rd_last", 64'(RdLast), 64'(rd_n == 15));
                  chk(Triggered == 1'b1, "trig_in_read", 64'(Triggered), 64'd1);
                  got[rd_n] = int'(RdData[15:0]);
                  rd_n++;
                  if (rd_n == 16) last_p = 1;
               end
            end
            stall_p = RdValid && !RdReady;
            hold_d  = RdData;
            hold_l  = RdLast;
         end
      end
   end

   task automatic drive(input bit arm, input bit frc, input logic [7:0] vm, input bit rdy,
                        input int pre, input int ch, input int lvl);
      @(posedge clk);
      #1;
      Arm          = arm;
      TrigForce    = frc;
      AdcDataValid = vm;
      RdReady      = rdy;
      PreTrig      = ABits'(pre);
      TrigChnl     = 3'(ch);
      TrigLevel    = 16'(lvl);
      AdcData      = {smp, smp, smp, smp};
      if (log_en && vm[3:0] == 4'hF) begin
         log_val.push_back(int'(smp));
         log_frc.push_back(frc);
      end
      smp = smp + 16'd1;
   endtask

   task automatic check_reset_outputs();
      chk(Busy == 1'b0, "rst_busy", 64'(Busy), 64'd0);
      chk(Triggered == 1'b0, "rst_triggered", 64'(Triggered), 64'd0);
      chk(Done == 1'b0, "rst_done", 64'(Done), 64'd0);
      chk(RdValid == 1'b0, "rst_rdvalid", 64'(RdValid), 64'd0);
      chk(RdLast == 1'b0, "rst_rdlast", 64'(RdLast), 64'd0);
      chk(RdData == '0, "rst_rddata", RdData, 64'd0);
   endtask

   // tid: 1 level, 2 force pre0, 3 gaps+early force, 4 backpressure, 5 abort, 6 pre 15
   task automatic run_test(input int tid, input logic [15:0] arm_v, input int pre, input int ch,
                           input int lvl, input int abort_at);
      int         d0, acc;
      bit         f, rdy, a2;
      logic [7:0] vm;
      d0 = done_cnt;
      acc = 0;
      log_val.delete();
      log_frc.delete();
      pre_m = pre;
      lvl_m = lvl;
      smp = arm_v;
      log_en = 1'b0;
      drive(1'b1, 1'b0, 8'h0F, 1'b1, pre, ch, lvl);
      log_en = 1'b1;
      for (int c = 0; c < 300 && done_cnt == d0; c++) begin
         vm = (tid == 3 && (c % 3) == 2) ? 8'h0D : 8'h0F;
         case (tid)
            2:       f = (acc == 2);
            3:       f = (acc <= 4);
            5:       f = (acc == 3);
            6:       f = 1'b1;
            default: f = 1'b0;
         endcase
         rdy = (tid == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
         a2  = (tid == 4 && c == 5);
         drive(a2, f, vm, rdy, a2 ? 1 : pre, a2 ? 0 : ch, a2 ? 0 : lvl);
         if (vm[3:0] == 4'hF) acc++;
         if (c == 0) begin
            @(negedge clk);
            chk(Busy == 1'b1, "busy_after_arm", 64'(Busy), 64'd1);
            chk(Done == 1'b0, "done_cleared_by_arm", 64'(Done), 64'd0);
            chk(Triggered == 1'b0, "trig_before_trigger", 64'(Triggered), 64'd0);
         end
         if (abort_at > 0 && c == abort_at) begin
            @(negedge clk);
            chk(Triggered == 1'b1 && Busy == 1'b1, "trig_in_post", 64'(Triggered), 64'd1);
            #2 rst_n = 1'b0;
            @(negedge clk);
            check_reset_outputs();
            repeat (2) @(posedge clk);
            @(negedge clk);
            #2 rst_n = 1'b1;
            return;
         end
      end
      chk(done_cnt != d0, "readout_timeout", 64'(done_cnt), 64'(d0 + 1));
   endtask

   initial begin
      rst_n = 1'b0; Arm = 1'b0; TrigForce = 1'b0; RdReady = 1'b0; AdcDataValid = 8'h00;
      AdcData = '0; TrigChnl = 3'd0; TrigLevel = 16'd0; PreTrig = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      #2 rst_n = 1'b1;

      run_test(1, 16'd0, 4, 2, 20, 0);
      chk(got[0] == 16, "t1_first", 64'(got[0]), 64'd16);
      chk(got[15] == 31, "t1_last", 64'(got[15]), 64'd31);

      run_test(2, 16'hFFFF, 0, 0, 0, 0);
      chk(got[0] == 2, "t2_first", 64'(got[0]), 64'd2);
      chk(got[15] == 17, "t2_last", 64'(got[15]), 64'd17);

      run_test(3, 16'd100, 4, 0, 65535, 0);
      chk(got[0] == 101, "t3_first", 64'(got[0]), 64'd101);
      chk(got[2] == 104, "t3_gap_skipped", 64'(got[2]), 64'd104);
      chk(got[4] == 107, "t3_trig_word", 64'(got[4]), 64'd107);
      chk(got[15] == 123, "t3_last", 64'(got[15]), 64'd123);

      run_test(4, 16'd200, 8, 1, 215, 0);
      chk(got[0] == 207, "t4_first", 64'(got[0]), 64'd207);
      chk(got[15] == 222, "t4_last", 64'(got[15]), 64'd222);

      run_test(5, 16'd250, 2, 0, 65535, 6);

      run_test(6, 16'd300, 15, 0, 65535, 0);
      chk(got[0] == 301, "t6_first", 64'(got[0]), 64'd301);
      chk(got[14] == 315, "t6_last_pre", 64'(got[14]), 64'd315);
      chk(got[15] == 316, "t6_trig_last", 64'(got[15]), 64'd316);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
